timestamp_word_decoder: RTL and testbench



---
 rtl/timestamp_word_decoder.sv | 188 ++++++++++++++++++
 tb/tb_timestamp_word_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_word_decoder.sv
// Timestamp word decoder.
// Pulls 32-bit words from the timestamp FIFO, keeps words carrying this block's identifier,
// pairs a low word (tag 1) with a following high word (tag 2) into a 48-bit timestamp, and
// presents it over valid/ready together with the modulo-2^48 delta to the previous timestamp.
// Protocol violations are tallied in saturating 8-bit counters.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear of state, pairing, history, counters, valid
//   fifo_empty_i         upstream FIFO empty
//   fifo_read_o          read strobe; fifo_data_i is valid exactly one cycle later
//   fifo_data_i          word: [31:28] id, [27:24] tag, [23:0] payload
//   ts_valid_o           timestamp valid, held until ts_ready_i
//   ts_ready_i           downstream accept
//   ts_data_o            {hi payload, lo payload}
//   ts_delta_o           ts_data_o minus previous emitted timestamp (0 when ts_first_o)
//   ts_first_o           no previous timestamp since reset/clear
//   *_cnt_o              saturating error counters
module timestamp_word_decoder #(
   parameter logic [3:0] Identifier = 4'b0001
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        fifo_empty_i,
   output logic        fifo_read_o,
   input  logic [31:0] fifo_data_i,
   output logic        ts_valid_o,
   input  logic        ts_ready_i,
   output logic [47:0] ts_data_o,
   output logic [47:0] ts_delta_o,
   output logic        ts_first_o,
   output logic [7:0]  foreign_cnt_o,
   output logic [7:0]  orphan_cnt_o,
   output logic [7:0]  dup_cnt_o,
   output logic [7:0]  badtag_cnt_o
);

   typedef enum logic [1:0] {StLoReq, StLoWait, StHiReq, StHiWait} state_e;

   state_e      state_q, state_d;
   logic [23:0] lo_q, lo_d;
   logic [47:0] prev_q, prev_d;
   logic        prev_valid_q, prev_valid_d;
   logic        ts_valid_q, ts_valid_d;
   logic [47:0] ts_data_q, ts_data_d;
   logic [47:0] ts_delta_q, ts_delta_d;
   logic        ts_first_q, ts_first_d;
   logic [7:0]  foreign_q, foreign_d;
   logic [7:0]  orphan_q, orphan_d;
   logic [7:0]  dup_q, dup_d;
   logic [7:0]  badtag_q, badtag_d;

   logic [3:0]  word_id;
   logic [3:0]  word_tag;
   logic [23:0] word_payload;
   logic [47:0] ts_new;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign word_id      = fifo_data_i[31:28];
   assign word_tag     = fifo_data_i[27:24];
   assign word_payload = fifo_data_i[23:0];
   assign ts_new       = {word_payload, lo_q};

   // A pending output blocks further reads so at most one timestamp is ever in flight.
   assign fifo_read_o = ((state_q == StLoReq) || (state_q == StHiReq)) && !fifo_empty_i &&
                        !ts_valid_q && !clear_i;

   always_comb begin
      state_d      = state_q;
      lo_d         = lo_q;
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      ts_valid_d   = ts_valid_q;
      ts_data_d    = ts_data_q;
      ts_delta_d   = ts_delta_q;
      ts_first_d   = ts_first_q;
      foreign_d    = foreign_q;
      orphan_d     = orphan_q;
      dup_d        = dup_q;
      badtag_d     = badtag_q;

      if (ts_valid_q && ts_ready_i) begin
         ts_valid_d = 1'b0;
      end

      if (clear_i) begin
         // The word returned in a WAIT cycle is dropped without being counted.
         state_d      = StLoReq;
         lo_d         = '0;
         prev_d       = '0;
         prev_valid_d = 1'b0;
         ts_valid_d   = 1'b0;
         foreign_d    = '0;
         orphan_d     = '0;
         dup_d        = '0;
         badtag_d     = '0;
      end else begin
         unique case (state_q)
            StLoReq: begin
               if (fifo_read_o) state_d = StLoWait;
            end
            StHiReq: begin
               if (fifo_read_o) state_d = StHiWait;
            end
            StLoWait: begin
               state_d = StLoReq;
               if (word_id != Identifier) begin
                  foreign_d = sat_inc(foreign_q);
               end else if (word_tag == 4'h1) begin
                  lo_d    = word_payload;
                  state_d = StHiReq;
               end else if (word_tag == 4'h2) begin
                  orphan_d = sat_inc(orphan_q);
               end else begin
                  badtag_d = sat_inc(badtag_q);
               end
            end
            StHiWait: begin
               if (word_id != Identifier) begin
                  foreign_d = sat_inc(foreign_q);
                  state_d   = StHiReq;
               end else if (word_tag == 4'h1) begin
                  // Newest low word wins.
                  dup_d   = sat_inc(dup_q);
                  lo_d    = word_payload;
                  state_d = StHiReq;
               end else if (word_tag == 4'h2) begin
                  ts_data_d    = ts_new;
                  ts_delta_d   = prev_valid_q ? (ts_new - prev_q) : 48'd0;
                  ts_first_d   = !prev_valid_q;
                  prev_d       = ts_new;
                  prev_valid_d = 1'b1;
                  ts_valid_d   = 1'b1;
                  state_d      = StLoReq;
               end else begin
                  badtag_d = sat_inc(badtag_q);
                  lo_d     = '0;
                  state_d  = StLoReq;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StLoReq;
         lo_q         <= '0;
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         ts_valid_q   <= 1'b0;
         ts_data_q    <= '0;
         ts_delta_q   <= '0;
         ts_first_q   <= 1'b0;
         foreign_q    <= '0;
         orphan_q     <= '0;
         dup_q        <= '0;
         badtag_q     <= '0;
      end else begin
         state_q      <= state_d;
         lo_q         <= lo_d;
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         ts_valid_q   <= ts_valid_d;
         ts_data_q    <= ts_data_d;
         ts_delta_q   <= ts_delta_d;
         ts_first_q   <= ts_first_d;
         foreign_q    <= foreign_d;
         orphan_q     <= orphan_d;
         dup_q        <= dup_d;
         badtag_q     <= badtag_d;
      end
   end

   assign ts_valid_o    = ts_valid_q;
   assign ts_data_o     = ts_data_q;
   assign ts_delta_o    = ts_delta_q;
   assign ts_first_o    = ts_first_q;
   assign foreign_cnt_o = foreign_q;
   assign orphan_cnt_o  = orphan_q;
   assign dup_cnt_o     = dup_q;
   assign badtag_cnt_o  = badtag_q;

endmodule

// File: tb/tb_timestamp_word_decoder.sv
// Bench for timestamp_word_decoder: emulates the upstream FIFO with a queue and predicts
// timestamps and counters from a word-level pairing model.
module tb_timestamp_word_decoder;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        clear_i;
   logic        fifo_empty_i;
   logic        fifo_read_o;
   logic [31:0] fifo_data_i;
   logic        ts_valid_o;
   logic        ts_ready_i;
   logic [47:0] ts_data_o;
   logic [47:0] ts_delta_o;
   logic        ts_first_o;
   logic [7:0]  foreign_cnt_o;
   logic [7:0]  orphan_cnt_o;
   logic [7:0]  dup_cnt_o;
   logic [7:0]  badtag_cnt_o;

   timestamp_word_decoder dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_read_o  (fifo_read_o),
      .fifo_data_i  (fifo_data_i),
      .ts_valid_o   (ts_valid_o),
      .ts_ready_i   (ts_ready_i),
      .ts_data_o    (ts_data_o),
      .ts_delta_o   (ts_delta_o),
      .ts_first_o   (ts_first_o),
      .foreign_cnt_o(foreign_cnt_o),
      .orphan_cnt_o (orphan_cnt_o),
      .dup_cnt_o    (dup_cnt_o),
      .badtag_cnt_o (badtag_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Upstream FIFO contents and the word currently presented on fifo_data_i.
   logic [31:0] fifo_q[$];
   bit          have_word = 0;
   logic [31:0] cur_word  = '0;

   // Word-level reference model.
   bit          m_have_lo;
   logic [23:0] m_lo;
   logic [47:0] m_prev;
   bit          m_prev_valid;
   int          m_foreign, m_orphan, m_dup, m_badtag;
   logic [47:0] exp_data_q[$];
   logic [47:0] exp_delta_q[$];
   bit          exp_first_q[$];

   int cyc         = 0;
   int last_rd_cyc = -100;
   bit prev_vld    = 0;
   bit prev_hs     = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   function automatic logic [31:0] mk(input logic [3:0] id, input logic [3:0] tag,
                                      input logic [23:0] p);
      return {id, tag, p};
   endfunction

   task automatic model_reset();
      m_have_lo = 0; m_lo = '0; m_prev = '0; m_prev_valid = 0;
      m_foreign = 0; m_orphan = 0; m_dup = 0; m_badtag = 0;
      exp_data_q.delete(); exp_delta_q.delete(); exp_first_q.delete();
   endtask

   task automatic model_apply(input logic [31:0] w);
      logic [47:0] ts;
      if (w[31:28] != 4'h1) begin
         m_foreign = sat(m_foreign);
      end else if (w[27:24] == 4'h1) begin
         if (m_have_lo) m_dup = sat(m_dup);
         m_lo = w[23:0];
         m_have_lo = 1;
      end else if (w[27:24] == 4'h2) begin
         if (!m_have_lo) begin
            m_orphan = sat(m_orphan);
         end else begin
            ts = {w[23:0], m_lo};
            exp_data_q.push_back(ts);
            exp_delta_q.push_back(m_prev_valid ? ts - m_prev : 48'd0);
            exp_first_q.push_back(!m_prev_valid);
            m_prev = ts;
            m_prev_valid = 1;
         end
         m_have_lo = 0;
      end else begin
         m_badtag = sat(m_badtag);
         m_have_lo = 0;
      end
   endtask

   task automatic check_counters(input string tag);
      check_val({tag, "_foreign"}, foreign_cnt_o, m_foreign);
      check_val({tag, "_orphan"}, orphan_cnt_o, m_orphan);
      check_val({tag, "_dup"}, dup_cnt_o, m_dup);
      check_val({tag, "_badtag"}, badtag_cnt_o, m_badtag);
   endtask

   // One clock cycle; entered and left at posedge+1.
   task automatic tick();
      logic        rd;
      logic        hs;
      logic [31:0] w;
      w = '0;
      fifo_empty_i = (fifo_q.size() == 0);
      #1;
      rd = fifo_read_o;
      if (ts_valid_o && !prev_vld) check_val("valid_latency", cyc - last_rd_cyc, 2);
      if (prev_hs) check_val("valid_drop", ts_valid_o, 0);
      if (ts_valid_o) begin
         check_val("read_blocked", rd, 0);
         if (exp_data_q.size() == 0) begin
            check_val("unexpected_ts", ts_data_o, 48'hx);
         end else begin
            check_val("ts_data", ts_data_o, exp_data_q[0]);
            check_val("ts_delta", ts_delta_o, exp_delta_q[0]);
            check_val("ts_first", ts_first_o, exp_first_q[0]);
         end
      end
      hs = ts_valid_o && ts_ready_i;
      if (rd) begin
         if (fifo_q.size() == 0) check_val("read_when_empty", rd, 0);
         else w = fifo_q.pop_front();
         last_rd_cyc = cyc;
      end
      prev_vld = ts_valid_o;
      prev_hs  = hs;
      @(posedge clk_i);
      #1;
      if (hs && exp_data_q.size() != 0) begin
         void'(exp_data_q.pop_front());
         void'(exp_delta_q.pop_front());
         void'(exp_first_q.pop_front());
      end
      if (clear_i) model_reset();
      else if (have_word) model_apply(cur_word);
      have_word   = rd;
      cur_word    = w;
      fifo_data_i = rd ? w : $urandom();
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 0;
      ts_ready_i = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (fifo_q.size() == 0 && !have_word && exp_data_q.size() == 0 && !ts_valid_o) begin
            done = 1;
            break;
         end
         tick();
      end
      check_val({tag, "_drained"}, done, 1);
      ticks(2);
   endtask

   task automatic push_pair(input logic [47:0] ts);
      fifo_q.push_back(mk(4'h1, 4'h1, ts[23:0]));
      fifo_q.push_back(mk(4'h1, 4'h2, ts[47:24]));
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, ts_valid_o, 0);
      check_val({tag, "_data"}, ts_data_o, 0);
      check_val({tag, "_delta"}, ts_delta_o, 0);
      check_val({tag, "_first"}, ts_first_o, 0);
      check_val({tag, "_read"}, fifo_read_o, 0);
      check_val({tag, "_cnts"}, {foreign_cnt_o, orphan_cnt_o, dup_cnt_o, badtag_cnt_o}, 0);
   endtask

   initial begin
      rst_ni       = 1'b0;
      clear_i      = 1'b0;
      fifo_empty_i = 1'b1;
      fifo_data_i  = '0;
      ts_ready_i   = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      #10 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Basic pair.
      ts_ready_i = 1'b1;
      fifo_q.push_back(mk(4'h1, 4'h1, 24'h123456));
      fifo_q.push_back(mk(4'h1, 4'h2, 24'hABCDEF));
      drain("basic");
      check_val("basic_data", ts_data_o, 48'hABCDEF123456);
      check_val("basic_first", ts_first_o, 1);
      check_val("basic_delta", ts_delta_o, 0);

      // Delta and wrap.
      push_pair(48'hABCDEF123460);
      drain("delta");
      check_val("delta_val", ts_delta_o, 48'hA);
      check_val("delta_first", ts_first_o, 0);
      push_pair(48'hFFFFFFFFFFFE);
      push_pair(48'h000000000001);
      drain("wrap");
      check_val("wrap_delta", ts_delta_o, 48'd3);

      // Foreign word between lo and hi.
      fifo_q.push_back(mk(4'h1, 4'h1, 24'h00AA55));
      fifo_q.push_back(mk(4'h5, 4'h2, 24'h777777));
      fifo_q.push_back(mk(4'h1, 4'h2, 24'h000010));
      drain("foreign");
      check_val("foreign_cnt", foreign_cnt_o, 1);
      check_val("foreign_data", ts_data_o, 48'h00001000AA55);

      // Protocol errors.
      fifo_q.push_back(mk(4'h1, 4'h2, 24'h999999));
      drain("orphan");
      check_val("orphan_cnt", orphan_cnt_o, 1);
      fifo_q.push_back(mk(4'h1, 4'h1, 24'h111111));
      fifo_q.push_back(mk(4'h1, 4'h1, 24'h222222));
      fifo_q.push_back(mk(4'h1, 4'h2, 24'h000001));
      drain("dup");
      check_val("dup_cnt", dup_cnt_o, 1);
      check_val("dup_data", ts_data_o, 48'h000001222222);
      fifo_q.push_back(mk(4'h1, 4'h7, 24'h0));
      drain("badtag");
      check_val("badtag_cnt", badtag_cnt_o, 1);
      for (int i = 0; i < 300; i++) fifo_q.push_back(mk(4'h1, 4'h2, 24'(i)));
      drain("sat");
      check_val("orphan_sat", orphan_cnt_o, 8'hFF);
      check_counters("errors");

      // Backpressure with three pairs queued.
      ts_ready_i = 1'b0;
      push_pair(48'h000100000001);
      push_pair(48'h000200000002);
      push_pair(48'h000300000003);
      ticks(4);
      ticks(10);
      check_val("bp_fifo_left", fifo_q.size(), 4);
      check_val("bp_valid_held", ts_valid_o, 1);
      drain("bp");
      check_val("bp_last", ts_data_o, 48'h000300000003);

      // CLEAR mid-pair.
      fifo_q.push_back(mk(4'h1, 4'h1, 24'h000333));
      ticks(3);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      check_val("clr_cnts", {foreign_cnt_o, orphan_cnt_o, dup_cnt_o, badtag_cnt_o}, 0);
      check_val("clr_valid", ts_valid_o, 0);
      fifo_q.push_back(mk(4'h1, 4'h2, 24'h000444));
      drain("clr_orphan");
      check_val("clr_orphan_cnt", orphan_cnt_o, 1);
      push_pair(48'h000555000666);
      drain("clr_pair");
      check_val("clr_first", ts_first_o, 1);

      // Asynchronous reset mid-pair.
      fifo_q.push_back(mk(4'h1, 4'h1, 24'h000777));
      ticks(3);
      fifo_empty_i = 1'b1;
      #3 rst_ni = 1'b0;
      #1;
      check_all_zero("arst");
      #2 rst_ni = 1'b1;
      model_reset();
      have_word = 0;
      prev_vld  = 0;
      prev_hs   = 0;
      @(posedge clk_i);
      #1;
      fifo_q.push_back(mk(4'h1, 4'h2, 24'h000888));
      drain("arst_orphan");
      check_val("arst_orphan_cnt", orphan_cnt_o, 1);
      push_pair(48'h000999000AAA);
      drain("arst_pair");
      check_val("arst_first", ts_first_o, 1);

      // Randomized traffic with random backpressure.
      for (int blk = 0; blk < 60; blk++) begin
         for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
            logic [3:0] id;
            logic [3:0] tag;
            id  = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h1;
            tag = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : 4'($urandom_range(1, 2));
            fifo_q.push_back(mk(id, tag, 24'($urandom())));
         end
         for (int k = 0; k < int'($urandom_range(5, 30)); k++) begin
            ts_ready_i = ($urandom_range(0, 3) != 0);
            tick();
         end
      end
      drain("rand");
      check_counters("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
